dvp_pixel_capture: RTL
======================

Name: dvp_pixel_capture

Overview:
Receive-side stage downstream of the DVP camera controller. Once the controller releases PWDN and drives XCLK, the camera returns PCLK, VSYNC, HREF and D[7:0]. This block samples those pins in the system clock domain, frames them, packs byte pairs into 16-bit RGB565 pixels and hands them to the downstream pixel pipeline through a valid/ready FIFO with overflow reporting.

Parameters:
DATA_W, 8, DVP data bus width
PXL_W, 16, output pixel width (2*DATA_W)
FIFO_DEPTH, 4, pixel FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock; same clock as the camera controller; PCLK <= clk/4
rst  in  1  asynchronous active-high reset
cap_en_i  in  1  capture enable (driven from the camera-start config bit)
dvp_pclk_i  in  1  camera pixel clock, asynchronous
dvp_vsync_i  in  1  frame sync, high during vertical blanking
dvp_href_i  in  1  line valid, high during active pixels
dvp_d_i  in  DATA_W  camera data
pxl_data_o  out  PXL_W  pixel {first byte, second byte}
pxl_sof_o  out  1  qualifies pxl_data_o as the first pixel of a frame
pxl_valid_o  out  1  pixel available
pxl_ready_i  in  1  downstream accept; transfer = valid & ready
frame_done_o  out  1  one-cycle pulse at the end of each captured frame
ovf_o  out  1  sticky overflow flag
ovf_clr_i  in  1  clears ovf_o

Behaviour:
- Reset: state IDLE; FIFO empty; pxl_valid_o=0; pxl_data_o=0; pxl_sof_o=0; frame_done_o=0; ovf_o=0; byte phase=0; sync and edge registers=0.
- Synchronisation: pclk, vsync, href and d each pass through two flops. A third pclk flop drives edge detection. A sample event occurs when the synchronised pclk is 1 and the previous value was 0. href, d and vsync are used from their second synchronising stage on that event.
- vsync rise and fall events are detected on the synchronised vsync (2 stages + 1 history flop).
- FSM:
  - IDLE: if cap_en_i=1, go to WAIT_FRAME.
  - WAIT_FRAME: if cap_en_i=0, go to IDLE immediately. Otherwise, on a vsync fall event, go to CAPTURE, set first_pxl=1, byte phase=0.
  - CAPTURE: on a vsync rise event, pulse frame_done_o on the next cycle. Then go to WAIT_FRAME if cap_en_i=1, else IDLE. cap_en_i=0 mid-frame does not abort; the frame completes.
- Packing, applied in CAPTURE on each sample event with href=1:
  - phase 0: store the byte as the high byte; set phase=1.
  - phase 1: push {high, byte} with sof=first_pxl; clear first_pxl; set phase=0.
  - A sample event with href=0 forces phase=0, so an odd trailing byte is discarded.
- FIFO: FIFO_DEPTH entries of {sof, data}, synchronous, registered outputs.
  - pxl_valid_o rises on the cycle after the first push into an empty FIFO.
  - Push and pop in the same cycle are both allowed at any occupancy, including full.
  - Data held under valid & !ready must remain stable.
- Overflow: a push while full and with no pop that cycle drops the pixel and sets ovf_o. Dropping the sof-tagged pixel leaves first_pxl cleared anyway. ovf_clr_i clears ovf_o; if a set and a clear occur in the same cycle, set wins.
- Latency: pin edge of the second byte to pxl_valid_o is 4 clk when the FIFO is empty (2 sync, 1 edge, 1 FIFO register).
- The FIFO keeps draining in IDLE/WAIT_FRAME; it is not flushed when cap_en_i drops.
- Reset mid-frame: everything returns to reset values; the next capture starts only after a fresh vsync fall.

Test Plan:
- cap_en=1, pclk=clk/8, one frame of 2 lines × 4 pixels, bytes 0x01,0x02,0x03,0x04…, ready=1 -> 8 pixels 0x0102,0x0304,…; sof only on 0x0102; one frame_done pulse after the vsync rise.
- Line with 5 href bytes A1..A5 -> pixels 0xA1A2 and 0xA3A4; A5 dropped; the next line starts at phase 0.
- ready=0 for an entire 8-pixel line -> 4 pixels held, 4 dropped, ovf_o=1. Then ready=1 -> first 4 pixels out in order, unchanged. ovf_clr pulse -> ovf_o=0.
- cap_en=0 asserted mid-frame -> the remaining pixels of that frame are captured, frame_done pulses, state IDLE, later frames ignored. cap_en=0 in WAIT_FRAME -> no pixels from the next frame.
- Capture starts while vsync=0 (mid-frame) -> no pixels until a vsync rise then fall; the first pixel of the next frame carries sof=1.
- rst pulse during a line with 2 pixels in the FIFO -> valid=0 immediately, FIFO empty, ovf=0; capture resumes only at the next vsync fall.

Source files
------------

// File: rtl/dvp_pixel_capture_if.sv
// rtl/dvp_pixel_capture_if.sv - pixel stream handshake bundle between capture and pixel pipeline
interface dvp_pixel_capture_if #(
  parameter int PXL_W = 16
);
  logic [PXL_W-1:0] pxl_data_o;
  logic             pxl_sof_o;
  logic             pxl_valid_o;
  logic             pxl_ready_i;

  modport master (
    output pxl_data_o,
    output pxl_sof_o,
    output pxl_valid_o,
    input  pxl_ready_i
  );

  modport slave (
    input  pxl_data_o,
    input  pxl_sof_o,
    input  pxl_valid_o,
    output pxl_ready_i
  );
endinterface

// File: rtl/dvp_pixel_capture.sv
// rtl/dvp_pixel_capture.sv - DVP pin sampler, frame FSM, RGB565 byte packer and pixel FIFO
module dvp_pixel_capture #(
  parameter int DATA_W     = 8,
  parameter int PXL_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en_i,
  input  logic              dvp_pclk_i,
  input  logic              dvp_vsync_i,
  input  logic              dvp_href_i,
  input  logic [DATA_W-1:0] dvp_d_i,
  dvp_pixel_capture_if.master pxl,
  output logic              frame_done_o,
  output logic              ovf_o,
  input  logic              ovf_clr_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE} state_t;

  state_t state, next_state;

  logic pclk_s1, pclk_s2, pclk_s3;
  logic vsync_s1, vsync_s2, vsync_s3;
  logic href_s1, href_s2;
  logic [DATA_W-1:0] d_s1, d_s2;

  logic sample, vsync_rise, vsync_fall;
  logic start_frame, done_set;

  logic              phase;
  logic              first_pxl;
  logic [DATA_W-1:0] hi_byte;
  logic              push_q;
  logic              push_sof;
  logic [PXL_W-1:0]  push_data;

  logic [PXL_W:0] mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count, count_next;
  logic           valid_q;
  logic           full, pop, push_ok, drop;

  // two-stage synchronisers plus history flops for pclk and vsync edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_s1  <= 1'b0; pclk_s2  <= 1'b0; pclk_s3  <= 1'b0;
      vsync_s1 <= 1'b0; vsync_s2 <= 1'b0; vsync_s3 <= 1'b0;
      href_s1  <= 1'b0; href_s2  <= 1'b0;
      d_s1     <= '0;   d_s2     <= '0;
    end else begin
      pclk_s1  <= dvp_pclk_i;  pclk_s2  <= pclk_s1;  pclk_s3  <= pclk_s2;
      vsync_s1 <= dvp_vsync_i; vsync_s2 <= vsync_s1; vsync_s3 <= vsync_s2;
      href_s1  <= dvp_href_i;  href_s2  <= href_s1;
      d_s1     <= dvp_d_i;     d_s2     <= d_s1;
    end
  end

  assign sample     = pclk_s2 & ~pclk_s3;
  assign vsync_rise = vsync_s2 & ~vsync_s3;
  assign vsync_fall = ~vsync_s2 & vsync_s3;

  // frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // frame next-state; a frame in progress always runs to its vsync rise
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    done_set    = 1'b0;
    case (state)
      IDLE: begin
        if (cap_en_i) next_state = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (!cap_en_i) begin
          next_state = IDLE;
        end else if (vsync_fall) begin
          next_state  = CAPTURE;
          start_frame = 1'b1;
        end
      end
      CAPTURE: begin
        if (vsync_rise) begin
          next_state = cap_en_i ? WAIT_FRAME : IDLE;
          done_set   = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // byte pairing into pixels; an href-low sample realigns to the high byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase        <= 1'b0;
      first_pxl    <= 1'b0;
      hi_byte      <= '0;
      push_q       <= 1'b0;
      push_sof     <= 1'b0;
      push_data    <= '0;
      frame_done_o <= 1'b0;
    end else begin
      push_q       <= 1'b0;
      frame_done_o <= done_set;
      if (start_frame) begin
        first_pxl <= 1'b1;
        phase     <= 1'b0;
      end else if (state == CAPTURE && sample) begin
        if (!href_s2) begin
          phase <= 1'b0;
        end else if (!phase) begin
          hi_byte <= d_s2;
          phase   <= 1'b1;
        end else begin
          push_q    <= 1'b1;
          push_data <= {hi_byte, d_s2};
          push_sof  <= first_pxl;
          first_pxl <= 1'b0;
          phase     <= 1'b0;
        end
      end
    end
  end

  assign full       = (count == CNT_FULL);
  assign pop        = valid_q & pxl.pxl_ready_i;
  assign push_ok    = push_q & (~full | pop);
  assign drop       = push_q & full & ~pop;
  assign count_next = count + (AW+1)'(push_ok) - (AW+1)'(pop);

  // pixel FIFO; when full with a pop, the write lands in the slot being read out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {push_sof, push_data};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count   <= count_next;
      valid_q <= (count_next != '0);
    end
  end

  // sticky overflow; a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ovf_o <= 1'b0;
    else if (drop)      ovf_o <= 1'b1;
    else if (ovf_clr_i) ovf_o <= 1'b0;
  end

  assign pxl.pxl_valid_o = valid_q;
  assign pxl.pxl_data_o  = mem[rd_ptr][PXL_W-1:0];
  assign pxl.pxl_sof_o   = valid_q & mem[rd_ptr][PXL_W];

endmodule
